// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the program loader.
//   ADDR_W / WORD_W / BYTE_W : instruction-memory address, word and byte widths
//   state_t                  : loader FSM state encoding
//   POST_PAYLOAD             : state entered once the last data word is in
// Optional feature macro: PROG_LOADER_CHKSUM_EN (adds the CHK state).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W = 12;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

`ifdef PROG_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DAT_HI = 3'd3,
        DAT_LO = 3'd4,
        CHK    = 3'd5,
        RUN    = 3'd6,
        ERR    = 3'd7
    } state_t;

    // The checksum byte follows the payload.
    localparam state_t POST_PAYLOAD = CHK;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DAT_HI = 3'd3,
        DAT_LO = 3'd4,
        RUN    = 3'd6,
        ERR    = 3'd7
    } state_t;

    // The stream ends with the last data byte.
    localparam state_t POST_PAYLOAD = RUN;
`endif

endpackage

// File: rtl/byte_pair.sv
// ---------------------------------------------------------------------------
// byte_pair -- assembles a big-endian byte pair into one 16-bit word.
//   clk, rst   : clock, synchronous active-high reset
//   hi_valid   : byte_data is the high byte of the next word
//   lo_valid   : byte_data is the low byte; completes the word
//   byte_data  : incoming byte
//   word       : last assembled word, held until the next lo_valid
//   word_valid : one-cycle pulse in the cycle after lo_valid
// ---------------------------------------------------------------------------
module byte_pair
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hi_valid,
    input  logic              lo_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [BYTE_W-1:0] hi_reg;
    logic [WORD_W-1:0] word_reg;
    logic              word_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg         <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= lo_valid;
            if (hi_valid) begin
                hi_reg <= byte_data;
            end
            // word only moves when a new pair completes, so it stays stable
            // while word_valid is low.
            if (lo_valid) begin
                word_reg <= {hi_reg, byte_data};
            end
        end
    end

    assign word       = word_reg;
    assign word_valid = word_valid_reg;

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader -- loads a program image from a byte stream into the CPU
// instruction memory, then enables the CPU.
// Stream: len_hi, len_lo, then per word hi byte, lo byte (big-endian);
// length is 12 bits {len_hi[3:0], len_lo}, len_hi[7:4] must be zero.
// With PROG_LOADER_CHKSUM_EN defined, one extra byte follows the payload and
// must equal the XOR of all length and data bytes.
//   clk, rst               : clock, synchronous active-high reset
//   start                  : one-cycle pulse, begins a load (IDLE/RUN/ERR)
//   byte_valid, byte_data  : incoming byte stream
//   byte_ready             : loader accepts a byte this cycle
//   we_IM, codein, immd    : instruction-memory write strobe, data, address
//   en                     : CPU run enable
//   busy, done, err        : status
// ---------------------------------------------------------------------------
module prog_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              we_IM,
    output logic [WORD_W-1:0] codein,
    output logic [ADDR_W-1:0] immd,
    output logic              en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t                  state_reg, state_next;
    logic [ADDR_W-BYTE_W-1:0] len_hi_reg;
    logic [ADDR_W-1:0]       words_left_reg;
    logic [ADDR_W-1:0]       wr_addr_reg;
    logic [ADDR_W-1:0]       immd_reg;
    logic                    en_reg;

    logic                    accept;
    logic                    hi_take;
    logic                    lo_take;
    logic                    start_load;
    logic [ADDR_W-1:0]       len_full;

`ifdef PROG_LOADER_CHKSUM_EN
    logic [BYTE_W-1:0]       chk_reg;
`endif

    assign accept     = byte_valid && byte_ready;
    assign len_full   = {len_hi_reg, byte_data};
    assign start_load = start && (state_reg == IDLE || state_reg == RUN ||
                                  state_reg == ERR);

    // ---------------- next state / combinational outputs ----------------
    always_comb begin
        state_next = state_reg;
        hi_take    = 1'b0;
        lo_take    = 1'b0;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) state_next = LEN_HI;
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    state_next = (byte_data[BYTE_W-1:ADDR_W-BYTE_W] != '0) ? ERR : LEN_LO;
                end
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    state_next = (len_full == '0) ? POST_PAYLOAD : DAT_HI;
                end
            end
            DAT_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    hi_take    = 1'b1;
                    state_next = DAT_LO;
                end
            end
            DAT_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    lo_take    = 1'b1;
                    state_next = (words_left_reg == ADDR_W'(1)) ? POST_PAYLOAD : DAT_HI;
                end
            end
`ifdef PROG_LOADER_CHKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    state_next = (byte_data == chk_reg) ? RUN : ERR;
                end
            end
`endif
            RUN: begin
                done = 1'b1;
                if (start) state_next = LEN_HI;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_next = LEN_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- state, counters and registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            len_hi_reg     <= '0;
            words_left_reg <= '0;
            wr_addr_reg    <= '0;
            immd_reg       <= '0;
            en_reg         <= 1'b0;
        end else begin
            state_reg <= state_next;
            // en follows RUN one cycle late so it never coincides with the
            // final write, and drops as soon as a reload is requested.
            en_reg    <= (state_reg == RUN) && (state_next == RUN);

            if (start_load) begin
                wr_addr_reg <= '0;
            end
            if (accept && state_reg == LEN_HI) begin
                len_hi_reg <= byte_data[ADDR_W-BYTE_W-1:0];
            end
            if (accept && state_reg == LEN_LO) begin
                words_left_reg <= len_full;
            end
            if (lo_take) begin
                // The address is latched with the pair; the write strobe
                // from byte_pair appears in the following cycle.
                immd_reg       <= wr_addr_reg;
                wr_addr_reg    <= wr_addr_reg + ADDR_W'(1);
                words_left_reg <= words_left_reg - ADDR_W'(1);
            end
        end
    end

`ifdef PROG_LOADER_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_reg <= '0;
        end else if (start_load) begin
            chk_reg <= '0;
        end else if (accept && state_reg != CHK) begin
            chk_reg <= chk_reg ^ byte_data;
        end
    end
`endif

    byte_pair u_byte_pair (
        .clk        (clk),
        .rst        (rst),
        .hi_valid   (hi_take),
        .lo_valid   (lo_take),
        .byte_data  (byte_data),
        .word       (codein),
        .word_valid (we_IM)
    );

    assign immd = immd_reg;
    assign en   = en_reg;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader -- self-checking bench for prog_loader.
// A reference model turns each byte stream into the expected list of
// (address, word) writes and the expected final status; a monitor records
// what the DUT actually wrote. Honours PROG_LOADER_CHKSUM_EN.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        we_IM;
    logic [15:0] codein;
    logic [11:0] immd;
    logic        en;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we_IM      (we_IM),
        .codein     (codein),
        .immd       (immd),
        .en         (en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // ---------------- monitor ----------------
    int          cyc = 0;
    logic [11:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];
    int          en_rise = -1;
    bit          en_prev = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #2;
        if (we_IM === 1'b1) begin
            wa_q.push_back(immd);
            wd_q.push_back(codein);
            wc_q.push_back(cyc);
        end
        if (en === 1'b1 && !en_prev && en_rise < 0) en_rise = cyc;
        en_prev = (en === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] xor_all(input logic [7:0] s[$]);
        logic [7:0] x = 8'h00;
        foreach (s[j]) x ^= s[j];
        return x;
    endfunction

    // Expected writes, expected error status and how many bytes the loader
    // will consume before it stops listening.
    function automatic void model(input logic [7:0] s[$],
                                  output logic [11:0] ea[$],
                                  output logic [15:0] ed[$],
                                  output bit eerr, output int n_take);
        logic [7:0] b0;
        int len;
        ea.delete();
        ed.delete();
        eerr = 1'b0;
        b0 = s[0];
        if (b0[7:4] != 4'h0) begin
            eerr   = 1'b1;
            n_take = 1;
            return;
        end
        len = int'(b0[3:0]) * 256 + int'(s[1]);
        for (int i = 0; i < len; i++) begin
            ea.push_back(12'(i));
            ed.push_back({s[2 + 2*i], s[3 + 2*i]});
        end
        n_take = 2 + 2*len;
`ifdef PROG_LOADER_CHKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int j = 0; j < n_take; j++) x ^= s[j];
            eerr   = (s[n_take] !== x);
            n_take = n_take + 1;
        end
`endif
    endfunction

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = (byte_ready === 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic append_chk(inout logic [7:0] s[$]);
`ifdef PROG_LOADER_CHKSUM_EN
        s.push_back(xor_all(s));
`endif
    endtask

    // Runs one load and checks writes, timing and final status.
    task automatic run_load(input string name, input logic [7:0] s[$],
                            input bit stall, input bit do_start);
        logic [11:0] ea[$];
        logic [15:0] ed[$];
        bit eerr;
        int n_take;
        bit ok;
        int t;
        model(s, ea, ed, eerr, n_take);
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        en_rise = -1;
        if (do_start) pulse_start();
        tests++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_busy_after_start: busy=%b byte_ready=%b, required 1 1", name, busy, byte_ready);
        end
        for (int i = 0; i < n_take; i++) begin
            if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(s[i], ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL %s_accept: byte %0d not accepted, required accept", name, i);
            end
        end
        t = 0;
        while (!(done === 1'b1 && en === 1'b1) && err !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        tests++;
        if (wa_q.size() != ea.size()) begin
            fails++;
            $display("FAIL %s_write_count: got %0d, required %0d", name, wa_q.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
            tests++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                fails++;
                $display("FAIL %s_write%0d: got addr=%h data=%h, required addr=%h data=%h",
                         name, i, wa_q[i], wd_q[i], ea[i], ed[i]);
            end
        end
        tests++;
        if (err !== eerr || en !== !eerr || done !== !eerr || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_status: err=%b en=%b done=%b busy=%b, required err=%b en=%b done=%b busy=0",
                     name, err, en, done, busy, eerr, !eerr, !eerr);
        end
        tests++;
        if (byte_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_ready_after: byte_ready=%b, required 0", name, byte_ready);
        end
        if (!eerr && wc_q.size() > 0) begin
            tests++;
            if (en_rise !== wc_q[wc_q.size()-1] + 1) begin
                fails++;
                $display("FAIL %s_en_timing: en rose at cycle %0d, required %0d",
                         name, en_rise, wc_q[wc_q.size()-1] + 1);
            end
        end
        $display("[TB] load %s: %0d bytes, %0d writes, err=%b en=%b", name, n_take, wa_q.size(), err, en);
    endtask

    function automatic void basic_stream(output logic [7:0] s[$]);
        s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        start = 1'b1;
        byte_valid = 1'b1;
        do_reset();
        start = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (we_IM !== 1'b0 || codein !== 16'h0 || immd !== 12'h0) begin
            fails++;
            $display("FAIL reset_write_port: we_IM=%b codein=%h immd=%h, required 0 0 0", we_IM, codein, immd);
        end
        tests++;
        if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: en=%b busy=%b done=%b err=%b, required 0 0 0 0", en, busy, done, err);
        end
        tests++;
        if (byte_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_idle: byte_ready=%b, required 0", byte_ready);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_basic();
        logic [7:0] s[$];
        basic_stream(s);
        append_chk(s);
        run_load("basic", s, 1'b0, 1'b1);
    endtask

    task automatic test_len_error();
        logic [7:0] s[$];
        s = '{8'h10, 8'h01};
        run_load("len_err", s, 1'b0, 1'b1);
        // The low length byte must not be taken once in ERR.
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (byte_ready !== 1'b0 || err !== 1'b1) begin
                fails++;
                $display("FAIL len_err_hold: byte_ready=%b err=%b, required 0 1", byte_ready, err);
            end
        end
        byte_valid = 1'b0;
        pulse_start();
        tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL len_err_restart: err=%b busy=%b, required 0 1", err, busy);
        end
        do_reset();
    endtask

    task automatic test_zero_len();
        logic [7:0] s[$];
        s = '{8'h00, 8'h00};
        append_chk(s);
        run_load("zero_len", s, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        logic [7:0] s[$];
        do_reset();
        tests++;
        if (byte_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_ready_idle: byte_ready=%b, required 0", byte_ready);
        end
        basic_stream(s);
        append_chk(s);
        run_load("stall", s, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        tests++;
        if (done !== 1'b1 || en !== 1'b1) begin
            fails++;
            $display("FAIL reload_precond: done=%b en=%b, required 1 1", done, en);
        end
        pulse_start();
        tests++;
        if (en !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reload_en_drop: en=%b done=%b, required 0 0", en, done);
        end
        s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        append_chk(s);
        run_load("reload", s, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            logic [7:0] s[$];
            int len;
            len = $urandom_range(1, 7);
            s.push_back(8'h00);
            s.push_back(8'(len));
            for (int i = 0; i < 2*len; i++) s.push_back(8'($urandom));
            append_chk(s);
            run_load($sformatf("random%0d", n), s, (n % 2) == 0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        pulse_start();
        send_byte(8'h00, ok);
        send_byte(8'h03, ok);
        send_byte(8'h12, ok);
        send_byte(8'h34, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (we_IM !== 1'b0 || codein !== 16'h0 || immd !== 12'h0 || en !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || byte_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_outputs: we=%b code=%h immd=%h en=%b busy=%b done=%b err=%b rdy=%b, required all 0",
                     we_IM, codein, immd, en, busy, done, err, byte_ready);
        end
        byte_valid = 1'b1;
        byte_data  = 8'hAB;
        repeat (8) @(negedge clk);
        byte_valid = 1'b0;
        tests++;
        if (wa_q.size() != 1) begin
            fails++;
            $display("FAIL rst_mid_writes: got %0d writes, required 1", wa_q.size());
        end else begin
            tests++;
            if (wa_q[0] !== 12'h000 || wd_q[0] !== 16'h1234) begin
                fails++;
                $display("FAIL rst_mid_first_write: addr=%h data=%h, required 000 1234", wa_q[0], wd_q[0]);
            end
        end
        $display("[TB] reset mid-load: %0d writes before reset", wa_q.size());
        begin
            logic [7:0] s[$];
            basic_stream(s);
            append_chk(s);
            run_load("after_rst", s, 1'b0, 1'b1);
        end
    endtask

`ifdef PROG_LOADER_CHKSUM_EN
    task automatic test_bad_chk();
        logic [7:0] s[$];
        do_reset();
        basic_stream(s);
        s.push_back(8'h50);
        run_load("bad_chk", s, 1'b0, 1'b1);
        pulse_start();
        tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL bad_chk_restart: err=%b busy=%b, required 0 1", err, busy);
        end
        do_reset();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_len_error();
        test_zero_len();
        test_stall();
        test_random();
        test_reset_mid();
`ifdef PROG_LOADER_CHKSUM_EN
        test_bad_chk();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
